// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply sequencer feeding an external Montgomery product unit.
// Latency: EXPW + popcount(e) + CONV products, each its unit latency plus ~3 cycles; start is ignored until idle.
module modexp_seq #(
    parameter int WID  = 256,
    parameter int EXPW = 256,
    parameter int IDXW = 8,
    parameter int CONV = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WID-1:0]  x_bar,
    input  logic [WID-1:0]  one_bar,
    input  logic [EXPW-1:0] e,
    input  logic [WID-1:0]  m,
    output logic            busy,
    output logic [WID-1:0]  res,
    output logic            res_valid,
    output logic [WID-1:0]  mp_a,
    output logic [WID-1:0]  mp_b,
    output logic [WID-1:0]  mp_m,
    output logic            mp_start,
    input  logic            mp_done,
    input  logic [WID-1:0]  mp_r
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_NEXT, S_FIN} state_t;
    typedef enum logic [1:0] {OP_SQR, OP_MUL, OP_CNV} op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WID-1:0]    acc_q, acc_d;
    logic [WID-1:0]    xb_q, xb_d;
    logic [EXPW-1:0]   e_q, e_d;
    logic [WID-1:0]    res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic [WID-1:0]    mp_a_q, mp_a_d;
    logic [WID-1:0]    mp_b_q, mp_b_d;
    logic [WID-1:0]    mp_m_q, mp_m_d;
    logic              mp_start_q, mp_start_d;
    logic              issue;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        xb_d        = xb_q;
        e_d         = e_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        busy_d      = busy_q;
        mp_a_d      = mp_a_q;
        mp_b_d      = mp_b_q;
        mp_m_d      = mp_m_q;
        mp_start_d  = 1'b0;
        issue       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xb_d       = x_bar;
                    e_d        = e;
                    mp_m_d     = m;
                    acc_d      = one_bar;
                    idx_d      = IDXW'(EXPW - 1);
                    op_d       = OP_SQR;
                    busy_d     = 1'b1;
                    mp_a_d     = one_bar;
                    mp_b_d     = one_bar;
                    mp_start_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_WAIT_LO;
            // done is a level: it must be seen low before a high counts as completion
            S_WAIT_LO: if (!mp_done) state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (mp_done) begin
                    acc_d   = mp_r;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (op_q == OP_SQR && e_q[idx_q]) begin
                    op_d  = OP_MUL;
                    issue = 1'b1;
                end else if (op_q != OP_CNV && idx_q != '0) begin
                    idx_d = idx_q - IDXW'(1);
                    op_d  = OP_SQR;
                    issue = 1'b1;
                end else if (op_q != OP_CNV && CONV != 0) begin
                    op_d  = OP_CNV;
                    issue = 1'b1;
                end else begin
                    res_d       = acc_q;
                    res_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            mp_a_d = acc_q;
            case (op_d)
                OP_MUL:  mp_b_d = xb_q;
                OP_CNV:  mp_b_d = WID'(1);
                default: mp_b_d = acc_q;
            endcase
            mp_start_d = 1'b1;
            state_d    = S_ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SQR;
            idx_q       <= IDXW'(EXPW - 1);
            acc_q       <= '0;
            xb_q        <= '0;
            e_q         <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mp_a_q      <= '0;
            mp_b_q      <= '0;
            mp_m_q      <= '0;
            mp_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            xb_q        <= xb_d;
            e_q         <= e_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            mp_a_q      <= mp_a_d;
            mp_b_q      <= mp_b_d;
            mp_m_q      <= mp_m_d;
            mp_start_q  <= mp_start_d;
        end
    end

    assign busy      = busy_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign mp_a      = mp_a_q;
    assign mp_b      = mp_b_q;
    assign mp_m      = mp_m_q;
    assign mp_start  = mp_start_q;

endmodule
